// File: rtl/mio_bus.sv
// -----------------------------------------------------------------------------
// mio_bus : data-side bridge between the CPU MEM stage and memory/peripherals.
//
// Accesses whose address bits [31:28] equal PERIPH_TAG go to the on-block
// peripherals. All other accesses go to the external data RAM. The peripherals
// are an LED register, a synchronised switch input, and a 32-bit compare timer
// that drives the CPU interrupt request.
//
// Peripheral word map (cpu_addr[7:2]):
//   0x00 LED  R/W      0x04 SW   RO        0x08 CNT  R/W
//   0x0C CMP  R/W      0x10 CTRL R/W (bit0 EN, bit1 IE, bit2 AR)
//   0x14 STAT bit0 PEND, write-1-to-clear
//
// Ports:
//   Clk_CPU, rst          clock and synchronous active-high reset
//   cpu_addr/cpu_wdata    CPU byte address and store data
//   cpu_mem_w/cpu_wea     CPU store strobe and byte-lane enables
//   cpu_rdata             combinational load data back to the CPU
//   ram_addr/ram_din/ram_we/ram_dout   external RAM interface
//   sw_in                 asynchronous switch inputs
//   led_out               LED register
//   INT                   registered timer interrupt request
// -----------------------------------------------------------------------------
module mio_bus #(
   parameter int unsigned RAM_ADDR_W = 10,
   parameter int unsigned LED_W      = 16,
   parameter int unsigned SW_W       = 16,
   parameter logic [3:0]  PERIPH_TAG = 4'hF
) (
   input  logic                  Clk_CPU,
   input  logic                  rst,
   input  logic [31:0]           cpu_addr,
   input  logic [31:0]           cpu_wdata,
   input  logic                  cpu_mem_w,
   input  logic [3:0]            cpu_wea,
   output logic [31:0]           cpu_rdata,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic [3:0]            ram_we,
   input  logic [31:0]           ram_dout,
   input  logic [SW_W-1:0]       sw_in,
   output logic [LED_W-1:0]      led_out,
   output logic                  INT
);

   localparam logic [5:0] OFF_LED  = 6'h00;
   localparam logic [5:0] OFF_SW   = 6'h01;
   localparam logic [5:0] OFF_CNT  = 6'h02;
   localparam logic [5:0] OFF_CMP  = 6'h03;
   localparam logic [5:0] OFF_CTRL = 6'h04;
   localparam logic [5:0] OFF_STAT = 6'h05;

   // Replace the byte lanes selected by be with the corresponding lanes of new_v.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   logic [LED_W-1:0] led_q, led_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      cmp_q, cmp_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             pend_q, pend_d;
   logic             int_q, int_d;
   logic [SW_W-1:0]  sw_s1_q, sw_s2_q;

   logic       periph;
   logic [5:0] off;
   logic       wr;
   logic       en, ie, ar;
   logic       match;

   // Address bits outside the decoded fields alias freely.
   logic unused_addr;
   assign unused_addr = ^{cpu_addr[27:8], cpu_addr[1:0]};

   assign periph = (cpu_addr[31:28] == PERIPH_TAG);
   assign off    = cpu_addr[7:2];
   assign wr     = cpu_mem_w & periph;

   assign en = ctrl_q[0];
   assign ie = ctrl_q[1];
   assign ar = ctrl_q[2];
   assign match = en && (cnt_q == cmp_q);

   assign ram_addr = cpu_addr[RAM_ADDR_W+1:2];
   assign ram_din  = cpu_wdata;
   assign ram_we   = (cpu_mem_w & ~periph) ? cpu_wea : 4'b0000;

   assign led_out = led_q;
   assign INT     = int_q;

   // Read mux: peripheral registers are presented combinationally in the
   // same MEM cycle, just like RAM data.
   always_comb begin
      cpu_rdata = ram_dout;
      if (periph) begin
         case (off)
            OFF_LED:  cpu_rdata = 32'(led_q);
            OFF_SW:   cpu_rdata = 32'(sw_s2_q);
            OFF_CNT:  cpu_rdata = cnt_q;
            OFF_CMP:  cpu_rdata = cmp_q;
            OFF_CTRL: cpu_rdata = {29'd0, ctrl_q};
            OFF_STAT: cpu_rdata = {31'd0, pend_q};
            default:  cpu_rdata = 32'd0;
         endcase
      end
   end

   // Next-state logic for the peripheral registers.
   always_comb begin
      led_d  = led_q;
      cnt_d  = cnt_q;
      cmp_d  = cmp_q;
      ctrl_d = ctrl_q;
      pend_d = pend_q;
      int_d  = pend_q & ie;

      if (wr && off == OFF_LED)
         led_d = LED_W'(lane_merge(32'(led_q), cpu_wdata, cpu_wea));
      if (wr && off == OFF_CMP)
         cmp_d = lane_merge(cmp_q, cpu_wdata, cpu_wea);
      if (wr && off == OFF_CTRL && cpu_wea[0])
         ctrl_d = cpu_wdata[2:0];

      // A CPU write to CNT takes priority over counting.
      if (wr && off == OFF_CNT)
         cnt_d = lane_merge(cnt_q, cpu_wdata, cpu_wea);
      else if (en)
         cnt_d = (match && ar) ? 32'd0 : cnt_q + 32'd1;

      // A match in the same cycle as a W1C keeps PEND set.
      if (match)
         pend_d = 1'b1;
      else if (wr && off == OFF_STAT && cpu_wea[0] && cpu_wdata[0])
         pend_d = 1'b0;
   end

   always_ff @(posedge Clk_CPU) begin
      if (rst) begin
         led_q   <= '0;
         cnt_q   <= '0;
         cmp_q   <= '0;
         ctrl_q  <= '0;
         pend_q  <= 1'b0;
         int_q   <= 1'b0;
         sw_s1_q <= '0;
         sw_s2_q <= '0;
      end else begin
         led_q   <= led_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         pend_q  <= pend_d;
         int_q   <= int_d;
         // Two-flop synchroniser for the asynchronous switches.
         sw_s1_q <= sw_in;
         sw_s2_q <= sw_s1_q;
      end
   end

endmodule

// File: tb/tb_mio_bus.sv
module tb_mio_bus;

   logic        clk;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_mem_w;
   logic [3:0]  cpu_wea;
   logic [31:0] cpu_rdata;
   logic [9:0]  ram_addr;
   logic [31:0] ram_din;
   logic [3:0]  ram_we;
   logic [31:0] ram_dout;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic        irq;

   int checks = 0;
   int fails  = 0;

   localparam logic [31:0] A_LED  = 32'hF000_0000;
   localparam logic [31:0] A_SW   = 32'hF000_0004;
   localparam logic [31:0] A_CNT  = 32'hF000_0008;
   localparam logic [31:0] A_CMP  = 32'hF000_000C;
   localparam logic [31:0] A_CTRL = 32'hF000_0010;
   localparam logic [31:0] A_STAT = 32'hF000_0014;

   mio_bus #(
      .RAM_ADDR_W(10),
      .LED_W(16),
      .SW_W(16),
      .PERIPH_TAG(4'hF)
   ) dut (
      .Clk_CPU  (clk),
      .rst      (rst),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_mem_w(cpu_mem_w),
      .cpu_wea  (cpu_wea),
      .cpu_rdata(cpu_rdata),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout),
      .sw_in    (sw_in),
      .led_out  (led_out),
      .INT      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle store; the bus returns to idle right after the edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wea   = be;
      cpu_mem_w = 1'b1;
      tick();
      cpu_mem_w = 1'b0;
      cpu_wea   = 4'b0000;
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      cpu_addr  = a;
      cpu_mem_w = 1'b0;
      #1;
      check(tag, cpu_rdata, exp);
   endtask

   initial begin
      rst       = 1'b1;
      cpu_addr  = 32'd0;
      cpu_wdata = 32'd0;
      cpu_mem_w = 1'b0;
      cpu_wea   = 4'b0000;
      ram_dout  = 32'd0;
      sw_in     = 16'd0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("reset_led", 32'(led_out), 32'd0);
      check("reset_int", 32'(irq), 32'd0);
      chk_rd("reset_cnt", A_CNT, 32'd0);
      chk_rd("reset_ctrl", A_CTRL, 32'd0);

      // RAM read and store
      ram_dout = 32'hDEAD_BEEF;
      chk_rd("ram_rdata", 32'h0000_0040, 32'hDEAD_BEEF);
      check("ram_addr", 32'(ram_addr), 32'h010);
      check("ram_we_idle", 32'(ram_we), 32'd0);
      cpu_wdata = 32'h1122_3344;
      cpu_wea   = 4'b0011;
      cpu_mem_w = 1'b1;
      #1;
      check("ram_we_store", 32'(ram_we), 32'h3);
      check("ram_din", ram_din, 32'h1122_3344);
      tick();
      cpu_mem_w = 1'b0;
      cpu_wea   = 4'b0000;
      check("ram_store_no_led", 32'(led_out), 32'd0);

      // LED write with a single byte lane
      cpu_addr  = A_LED;
      cpu_wdata = 32'hFFFF_A5A5;
      cpu_wea   = 4'b0001;
      cpu_mem_w = 1'b1;
      #1;
      check("led_store_ram_we", 32'(ram_we), 32'd0);
      tick();
      cpu_mem_w = 1'b0;
      cpu_wea   = 4'b0000;
      check("led_out", 32'(led_out), 32'h0000_00A5);
      chk_rd("led_rd", A_LED, 32'h0000_00A5);

      // Switch synchroniser latency
      sw_in = 16'h1234;
      chk_rd("sw_edge0", A_SW, 32'd0);
      tick();
      chk_rd("sw_edge1", A_SW, 32'd0);
      tick();
      chk_rd("sw_edge2", A_SW, 32'h0000_1234);

      // Timer with auto-reload: CMP=5, CNT=0, CTRL=EN|IE|AR
      store(A_CMP, 32'd5, 4'b1111);
      store(A_CNT, 32'd0, 4'b1111);
      store(A_CTRL, 32'h7, 4'b1111);
      chk_rd("tmr_cnt0", A_CNT, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk_rd($sformatf("tmr_cnt%0d", i), A_CNT, 32'(i));
      end
      chk_rd("tmr_pend_before", A_STAT, 32'd0);
      tick();
      chk_rd("tmr_reload", A_CNT, 32'd0);
      chk_rd("tmr_pend_set", A_STAT, 32'd1);
      check("tmr_int_lag", 32'(irq), 32'd0);
      tick();
      check("tmr_int_rise", 32'(irq), 32'd1);
      chk_rd("tmr_cnt_after", A_CNT, 32'd1);

      // W1C on STAT, INT follows one edge later
      store(A_STAT, 32'd1, 4'b0001);
      chk_rd("w1c_pend", A_STAT, 32'd0);
      check("w1c_int_hold", 32'(irq), 32'd1);
      tick();
      check("w1c_int_fall", 32'(irq), 32'd0);
      chk_rd("w1c_cnt", A_CNT, 32'd3);

      // Wrap at 2^32 with EN only
      store(A_CTRL, 32'h1, 4'b1111);
      store(A_CNT, 32'hFFFF_FFFF, 4'b1111);
      chk_rd("wrap_pre", A_CNT, 32'hFFFF_FFFF);
      tick();
      chk_rd("wrap_zero", A_CNT, 32'd0);

      // Write beats increment
      store(A_CNT, 32'h100, 4'b1111);
      chk_rd("cnt_wr_wins", A_CNT, 32'h100);
      tick();
      chk_rd("cnt_inc_after_wr", A_CNT, 32'h101);

      // Match without auto-reload, then reset mid-count
      store(A_CTRL, 32'h3, 4'b1111);
      store(A_CMP, 32'h103, 4'b1111);
      chk_rd("noar_cnt", A_CNT, 32'h103);
      tick();
      chk_rd("noar_cnt_inc", A_CNT, 32'h104);
      chk_rd("noar_pend", A_STAT, 32'd1);
      tick();
      check("noar_int", 32'(irq), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_rd("rst_cnt", A_CNT, 32'd0);
      chk_rd("rst_ctrl", A_CTRL, 32'd0);
      chk_rd("rst_stat", A_STAT, 32'd0);
      check("rst_int", 32'(irq), 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
      tick();
      chk_rd("rst_cnt_held", A_CNT, 32'd0);
      chk_rd("unmapped_rd", 32'hF000_0020, 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
